sign_extender: RTL and testbench

- Immediate generator and sign extender for the RISC-V single-cycle datapath.
- Takes a 32-bit input word (a raw instruction or a narrow immediate) and a format select, and produces a 32-bit extended immediate.
- The result is registered: valid one clock after the input is presented.
- Feeds the ALU B-operand mux and the branch/jump target adders.

---
 rtl/sign_extender_if.sv | 34 +++
 rtl/sign_extender.sv | 79 +++++++
 tb/tb_sign_extender.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/sign_extender_if.sv
`default_nettype none
// ============================================================================
//  Module   : sign_extender_if
//  Brief    : Request/result bundle between the datapath and the immediate
//             generator. The master presents a word and a format select; the
//             slave returns the registered, extended immediate.
//  Revision : 1.0  initial release
// ============================================================================
interface sign_extender_if;

    logic [31:0] in_data;
    logic [2:0]  fmt_sel;
    logic        valid_in;
    logic [31:0] out_data;
    logic        valid_out;

    modport master (
        output in_data,
        output fmt_sel,
        output valid_in,
        input  out_data,
        input  valid_out
    );

    modport slave (
        input  in_data,
        input  fmt_sel,
        input  valid_in,
        output out_data,
        output valid_out
    );

endinterface : sign_extender_if
`default_nettype wire

// File: rtl/sign_extender.sv
`default_nettype none
// ============================================================================
//  Module   : sign_extender
//  Brief    : RISC-V immediate generator / sign extender. Decodes the
//             immediate selected by fmt_sel out of a 32-bit word and registers
//             the 32-bit result with a one-cycle latency.
//  Revision : 1.0  initial release
// ============================================================================
module sign_extender #(
    parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    sign_extender_if.slave bus
);

    // Format select encoding
    localparam logic [2:0] c_FMT_EXT16  = 3'd0;
    localparam logic [2:0] c_FMT_I      = 3'd1;
    localparam logic [2:0] c_FMT_S      = 3'd2;
    localparam logic [2:0] c_FMT_B      = 3'd3;
    localparam logic [2:0] c_FMT_U      = 3'd4;
    localparam logic [2:0] c_FMT_J      = 3'd5;
    localparam logic [2:0] c_FMT_EXT8   = 3'd6;
    localparam logic [2:0] c_FMT_ZEXT16 = 3'd7;

    logic [31:0] w_in;
    logic [31:0] w_imm;
    logic [31:0] out_data_d;
    logic [31:0] out_data_q;
    logic        valid_out_d;
    logic        valid_out_q;

    assign w_in = bus.in_data;

    // Immediate decode: pure function of the presented word and format
    always_comb begin
        w_imm = 32'h0000_0000;
        case (bus.fmt_sel)
            c_FMT_EXT16:  w_imm = {{16{w_in[15]}}, w_in[15:0]};
            c_FMT_I:      w_imm = {{20{w_in[31]}}, w_in[31:20]};
            c_FMT_S:      w_imm = {{20{w_in[31]}}, w_in[31:25], w_in[11:7]};
            c_FMT_B:      w_imm = {{19{w_in[31]}}, w_in[31], w_in[7],
                                   w_in[30:25], w_in[11:8], 1'b0};
            c_FMT_U:      w_imm = {w_in[31:12], 12'h000};
            c_FMT_J:      w_imm = {{11{w_in[31]}}, w_in[31], w_in[19:12],
                                   w_in[20], w_in[30:21], 1'b0};
            c_FMT_EXT8:   w_imm = {{24{w_in[7]}}, w_in[7:0]};
            c_FMT_ZEXT16: w_imm = {16'h0000, w_in[15:0]};
            default:      w_imm = 32'h0000_0000;
        endcase
    end

    // Next state: capture on a qualified input, otherwise hold the data and
    // drop valid so consumers never see a stale result flagged as new
    always_comb begin
        out_data_d  = out_data_q;
        valid_out_d = bus.valid_in;
        if (bus.valid_in) begin
            out_data_d = w_imm;
        end
    end

    // Output registers; reset discards any capture pending on this edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= RESET_VALUE;
            valid_out_q <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            valid_out_q <= valid_out_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.valid_out = valid_out_q;

endmodule : sign_extender
`default_nettype wire

// File: tb/tb_sign_extender.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sign_extender
//  Brief    : Self-checking bench for sign_extender: arithmetic reference
//             model, per-cycle compare, directed literal cases and random
//             traffic with occasional asynchronous resets.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sign_extender;

    localparam logic [31:0] c_RESET_VALUE = 32'h0000_0000;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_pass;

    sign_extender_if bus ();

    sign_extender #(.RESET_VALUE(c_RESET_VALUE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference immediate computed with signed arithmetic and shifts
    function automatic logic [31:0] ref_imm(input logic [31:0] in, input logic [2:0] fmt);
        int      s;
        shortint h;
        byte     b8;
        s = int'(in);
        case (fmt)
            3'd0: begin h = shortint'(in[15:0]); return 32'(int'(h)); end
            3'd1: return 32'(s >>> 20);
            3'd2: return 32'(((s >>> 25) <<< 5) | int'(in[11:7]));
            3'd3: return 32'(((s >>> 31) <<< 12) | (int'(in[7]) << 11)
                             | (int'(in[30:25]) << 5) | (int'(in[11:8]) << 1));
            3'd4: return in & 32'hFFFF_F000;
            3'd5: return 32'(((s >>> 31) <<< 20) | (int'(in[19:12]) << 12)
                             | (int'(in[20]) << 11) | (int'(in[30:21]) << 1));
            3'd6: begin b8 = byte'(in[7:0]); return 32'(int'(b8)); end
            default: return in & 32'h0000_FFFF;
        endcase
    endfunction

    // Instruction builders from a signed byte offset
    function automatic logic [31:0] enc_b(input int off);
        logic [12:0] im;
        im = 13'(off);
        return {im[12], im[10:5], 5'd2, 5'd1, 3'b000, im[4:1], im[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(input int off);
        logic [20:0] im;
        im = 21'(off);
        return {im[20], im[10:1], im[11], im[19:12], 5'd1, 7'h6F};
    endfunction

    // Expected register contents: follows the input rules at each edge
    logic [31:0] m_data;
    logic        m_valid;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data  = c_RESET_VALUE;
            m_valid = 1'b0;
        end else begin
            m_valid = bus.valid_in;
            if (bus.valid_in) m_data = ref_imm(bus.in_data, bus.fmt_sel);
        end
    end

    // Every-cycle compare against the model, away from the active edge
    always @(negedge clk) begin
        n_total++;
        if (bus.out_data === m_data && bus.valid_out === m_valid) begin
            n_pass++;
        end else begin
            $display("FAIL cycle_compare t=%0t: got data=%h valid=%b expected data=%h valid=%b",
                     $time, bus.out_data, bus.valid_out, m_data, m_valid);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Present one input and return 2 ns after the capturing edge
    task automatic apply(input logic v, input logic [31:0] d, input logic [2:0] f);
        bus.valid_in = v;
        bus.in_data  = d;
        bus.fmt_sel  = f;
        @(posedge clk);
        #2;
    endtask

    // Capture one word, then check both the DUT and the model against a literal
    task automatic lit(input string name, input logic [31:0] d, input logic [2:0] f,
                       input logic [31:0] exp);
        chk({name, "_model"}, ref_imm(d, f), exp);
        apply(1'b1, d, f);
        chk(name, bus.out_data, exp);
        chk({name, "_valid"}, 32'(bus.valid_out), 32'd1);
    endtask

    logic [31:0] held;

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst_n   = 1'b0;
        bus.valid_in = 1'b1;
        bus.in_data  = 32'h0000_FFFF;
        bus.fmt_sel  = 3'd0;

        // Reset holds outputs even with a qualified input present
        repeat (3) @(posedge clk);
        #2;
        chk("reset_data", bus.out_data, c_RESET_VALUE);
        chk("reset_valid", 32'(bus.valid_out), 32'd0);
        rst_n = 1'b1;
        lit("post_reset_ext16", 32'h0000_FFFF, 3'd0, 32'hFFFF_FFFF);

        // Narrow extensions
        lit("ext16_pos",  32'h0000_7FFF, 3'd0, 32'h0000_7FFF);
        lit("ext16_neg",  32'hABCD_8000, 3'd0, 32'hFFFF_8000);
        lit("zext16",     32'h0000_FFFF, 3'd7, 32'h0000_FFFF);
        lit("zext16_hi",  32'hFFFF_FFFF, 3'd7, 32'h0000_FFFF);
        lit("ext8",       32'h0000_0080, 3'd6, 32'hFFFF_FF80);
        lit("ext8_hi",    32'hFFFF_FF7F, 3'd6, 32'h0000_007F);

        // RISC-V formats
        lit("itype_addi", 32'hFFF0_0093, 3'd1, 32'hFFFF_FFFF);
        lit("stype_sw",   32'hFE11_2E23, 3'd2, 32'hFFFF_FFFC);
        lit("utype_lui",  32'h1234_50B7, 3'd4, 32'h1234_5000);
        lit("btype_m8",   enc_b(-8),     3'd3, 32'hFFFF_FFF8);
        lit("btype_p2048", enc_b(2048),  3'd3, 32'h0000_0800);
        lit("jtype_m8",   enc_j(-8),     3'd5, 32'hFFFF_FFF8);
        lit("jtype_p2048", enc_j(2048),  3'd5, 32'h0000_0800);
        chk("bj_bit0", {31'd0, bus.out_data[0]}, 32'd0);

        // Hold: unqualified inputs must not disturb the result
        held = bus.out_data;
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, $urandom, 3'($urandom_range(0, 7)));
            chk("hold_data", bus.out_data, held);
            chk("hold_valid", 32'(bus.valid_out), 32'd0);
        end

        // Streaming: four formats back to back, one result per cycle
        lit("stream_ext16", 32'h0000_7FFF, 3'd0, 32'h0000_7FFF);
        lit("stream_i",     32'hFFF0_0093, 3'd1, 32'hFFFF_FFFF);
        lit("stream_s",     32'hFE11_2E23, 3'd2, 32'hFFFF_FFFC);
        lit("stream_u",     32'h1234_50B7, 3'd4, 32'h1234_5000);

        // Mid-stream asynchronous reset between edges
        apply(1'b1, 32'hFFF0_0093, 3'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_data", bus.out_data, c_RESET_VALUE);
        chk("async_rst_valid", 32'(bus.valid_out), 32'd0);
        apply(1'b1, 32'h0000_FFFF, 3'd0);
        chk("rst_no_capture", bus.out_data, c_RESET_VALUE);
        rst_n = 1'b1;
        lit("first_after_rst", 32'h0000_0080, 3'd6, 32'hFFFF_FF80);

        // Random traffic with occasional short reset pulses
        for (int i = 0; i < 400; i++) begin
            apply(($urandom_range(0, 3) != 0), $urandom, 3'($urandom_range(0, 7)));
            if ($urandom_range(0, 49) == 0) begin
                #1 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
        end
        bus.valid_in = 1'b0;
        repeat (2) @(posedge clk);
        #6;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_sign_extender
`default_nettype wire
